// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART packet ALU engine.
// Opcodes, FSM state encoding, framing constants and link timing.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;

  localparam int         HDR_LEN  = 4;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam int BAUD_RATE   = 115200;
  localparam int CLK_FREQ_HZ = 50_000_000;

  typedef enum logic [3:0] {
    IDLE,
    RSV,
    LEN_LO,
    LEN_HI,
    ECHO,
    COLLECT,
    COMPUTE,
    SEND,
    DRAIN
  } state_t;

  function automatic logic is_arith(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/uart_alu_acc.sv
// Operand assembler and add/mul reducer; bytes shift in LSB-first, a completed
// operand stays pending until the FSM strobes fold (result already includes it).
module uart_alu_acc
  import uart_alu_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int cnt_width_p = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               fold,
  input  logic               mul,
  input  logic [7:0]         byte_in,
  output logic               pending,
  output logic [width_p-1:0] result
);

  localparam logic [3:0] LAST_BYTE = 4'(width_p / 8 - 1);

  logic [width_p-1:0]     op_sr;
  logic [width_p-1:0]     acc;
  logic [width_p-1:0]     folded;
  logic [3:0]             byte_cnt;
  logic [cnt_width_p-1:0] op_cnt;

  always_comb begin
    folded = op_sr;
    if (op_cnt != '0) begin
      if (mul) folded = acc * op_sr;
      else     folded = acc + op_sr;
    end
    result = pending ? folded : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sr    <= '0;
      acc      <= '0;
      byte_cnt <= '0;
      pending  <= 1'b0;
      op_cnt   <= '0;
    end else if (clear) begin
      op_sr    <= '0;
      acc      <= '0;
      byte_cnt <= '0;
      pending  <= 1'b0;
      op_cnt   <= '0;
    end else begin
      if (fold) begin
        acc     <= folded;
        op_cnt  <= op_cnt + cnt_width_p'(1);
        pending <= 1'b0;
      end
      // A new completion in the same cycle as a fold re-arms pending.
      if (load) begin
        op_sr <= (op_sr >> 8) | (width_p'(byte_in) << (width_p - 8));
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          pending  <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_alu_engine.sv
// Length-framed packet ALU between UART RX/TX byte streams (echo, add, mul).
// First result byte 2 cycles after last RX byte; RX held off in COMPUTE/SEND. Option: UART_ALU_ERR_RESP_EN.
module uart_alu_engine
  import uart_alu_pkg::*;
#(
  parameter int datawidth_p     = 8,
  parameter int operand_width_p = 32,
  parameter int len_width_p     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic [7:0]             err_count_o
);

  localparam int NB = operand_width_p / 8;

  state_t state, state_d;

  logic [7:0]                 opcode;
  logic [7:0]                 len_lo;
  logic [len_width_p-1:0]     remaining;
  logic [len_width_p-1:0]     pkt_len;
  logic [operand_width_p-1:0] res_sr;
  logic [operand_width_p-1:0] res_shift;
  logic [3:0]                 send_cnt;
  logic [7:0]                 tx_dat;
  logic                       tx_vld;
  logic [7:0]                 err_cnt;

  logic rdy, tx_fire, bad;
  logic op_load, len_lo_load, rem_load, rem_dec;
  logic acc_clear, acc_load, acc_fold;
  logic tx_echo, tx_res, tx_err, tx_next, tx_done, err_inc;
  logic                       pending;
  logic [operand_width_p-1:0] result;

  assign pkt_len   = len_width_p'({rx_data_i, len_lo});
  assign res_shift = res_sr >> 8;
  assign tx_fire   = tx_vld & tx_ready_i;

  assign rx_ready_o  = rdy & ~rst_i;
  assign tx_valid_o  = tx_vld;
  assign tx_data_o   = tx_dat;
  assign busy_o      = (state != IDLE);
  assign err_count_o = err_cnt;

  uart_alu_acc #(
    .width_p     (operand_width_p),
    .cnt_width_p (len_width_p)
  ) u_acc (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (acc_clear),
    .load    (acc_load),
    .fold    (acc_fold),
    .mul     (opcode == OP_MUL),
    .byte_in (rx_data_i),
    .pending (pending),
    .result  (result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    rdy         = 1'b0;
    bad         = 1'b0;
    op_load     = 1'b0;
    len_lo_load = 1'b0;
    rem_load    = 1'b0;
    rem_dec     = 1'b0;
    acc_clear   = 1'b0;
    acc_load    = 1'b0;
    acc_fold    = 1'b0;
    tx_echo     = 1'b0;
    tx_res      = 1'b0;
    tx_err      = 1'b0;
    tx_next     = 1'b0;
    tx_done     = 1'b0;
    err_inc     = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          op_load   = 1'b1;
          acc_clear = 1'b1;
          state_d   = RSV;
        end
      end
      RSV: begin
        rdy = 1'b1;
        if (rx_valid_i) state_d = LEN_LO;
      end
      LEN_LO: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          len_lo_load = 1'b1;
          state_d     = LEN_HI;
        end
      end
      LEN_HI: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          rem_load = 1'b1;
          if (pkt_len < len_width_p'(HDR_LEN)) begin
            bad = 1'b1;
          end else if (pkt_len == len_width_p'(HDR_LEN)) begin
            if (opcode == OP_ECHO)     state_d = IDLE;
            else if (is_arith(opcode)) state_d = COMPUTE;
            else                       bad     = 1'b1;
          end else begin
            if (opcode == OP_ECHO)     state_d = ECHO;
            else if (is_arith(opcode)) state_d = COLLECT;
            else                       state_d = DRAIN;
          end
        end
      end
      ECHO: begin
        rdy = (!tx_vld || tx_ready_i) && (remaining != '0);
        if (rx_valid_i && rdy) begin
          tx_echo = 1'b1;
          rem_dec = 1'b1;
        end else if (tx_fire) begin
          tx_done = 1'b1;
        end
        if (remaining == '0 && (!tx_vld || tx_fire)) state_d = IDLE;
      end
      COLLECT: begin
        rdy      = 1'b1;
        acc_fold = pending;
        if (rx_valid_i) begin
          acc_load = 1'b1;
          rem_dec  = 1'b1;
          if (remaining == len_width_p'(1)) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_fold = pending;
        tx_res   = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_fire) begin
          if (send_cnt == 4'd0) begin
            tx_done = 1'b1;
            state_d = IDLE;
          end else begin
            tx_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          rem_dec = 1'b1;
          if (remaining == len_width_p'(1)) bad = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bad) begin
      err_inc = 1'b1;
`ifdef UART_ALU_ERR_RESP_EN
      tx_err  = 1'b1;
      state_d = SEND;
`else
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opcode    <= '0;
      len_lo    <= '0;
      remaining <= '0;
      res_sr    <= '0;
      send_cnt  <= '0;
      tx_dat    <= '0;
      tx_vld    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (op_load)     opcode <= rx_data_i;
      if (len_lo_load) len_lo <= rx_data_i;

      if (rem_load)     remaining <= pkt_len - len_width_p'(HDR_LEN);
      else if (rem_dec) remaining <= remaining - len_width_p'(1);

      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (tx_res) begin
        res_sr   <= result;
        tx_dat   <= result[7:0];
        tx_vld   <= 1'b1;
        send_cnt <= 4'(NB - 1);
      end else if (tx_err) begin
        tx_dat   <= ERR_BYTE;
        tx_vld   <= 1'b1;
        send_cnt <= 4'd0;
      end else if (tx_echo) begin
        tx_dat <= rx_data_i;
        tx_vld <= 1'b1;
      end else if (tx_next) begin
        res_sr   <= res_shift;
        tx_dat   <= res_shift[7:0];
        send_cnt <= send_cnt - 4'd1;
      end else if (tx_done) begin
        tx_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed bench for uart_alu_engine: drives packets, collects TX bytes, checks
// results, latency, backpressure stability, error counting and async reset.
module tb_uart_alu_engine;

  logic       clk;
  logic       rst_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic [7:0] err_count_o;

  int vectors     = 0;
  int miscompares = 0;

  int ncyc = 0;
  int last_fire = 0;
  int rise_cyc = 0;
  int stall_err = 0;
  bit bp_mode = 0;
  bit stalled = 0;
  bit prev_vld = 0;
  logic [7:0] stall_dat = '0;

  logic [7:0] pkt_q[$];
  logic [7:0] got_q[$];

  uart_alu_engine dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .busy_o      (busy_o),
    .err_count_o (err_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) ncyc <= ncyc + 1;

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready_i = bp_mode ? ((ncyc % 3) == 0) : 1'b1;
    end
  end

  // TX monitor: collects transferred bytes and flags data changing while stalled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (stalled && (tx_valid_o !== 1'b1 || tx_data_o !== stall_dat)) stall_err++;
      if (tx_valid_o === 1'b1 && !prev_vld) rise_cyc = ncyc;
      if (tx_valid_o === 1'b1 && tx_ready_i) got_q.push_back(tx_data_o);
      stalled   = (tx_valid_o === 1'b1) && !tx_ready_i;
      stall_dat = tx_data_o;
      prev_vld  = (tx_valid_o === 1'b1);
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int g = 0; g < 400 && !done; g++) begin
      #1;
      if (rx_ready_o === 1'b1) begin
        done = 1;
        last_fire = ncyc;
      end
      @(negedge clk);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_accept byte=%h never accepted, required acceptance within 400 cycles", b);
    end
  endtask

  task automatic send_pkt();
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 300 && got_q.size() < n; i++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [31:0] word_at(input int base);
    if (got_q.size() < base + 4) return 'x;
    return {got_q[base+3], got_q[base+2], got_q[base+1], got_q[base]};
  endfunction

  task automatic test_reset();
    #1;
    vectors++; if (rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_rx_ready got=%b want=0", rx_ready_o); end
    vectors++; if (tx_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid_o); end
    vectors++; if (tx_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got=%h want=00", tx_data_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    vectors++; if (err_count_o !== 8'd0) begin miscompares++; $display("FAIL reset_err_count got=%0d want=0", err_count_o); end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    vectors++; if (rx_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_rx_ready got=%b want=1", rx_ready_o); end
    @(negedge clk);
  endtask

  task automatic test_add();
    got_q.delete();
    pkt_q = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_tx(4);
    vectors++; if (word_at(0) !== 32'h0000_0003) begin miscompares++; $display("FAIL add_result got=%h want=00000003", word_at(0)); end
    vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL add_bytes got=%0d want=4", got_q.size()); end
    vectors++; if (rise_cyc - last_fire !== 2) begin miscompares++; $display("FAIL add_latency got=%0d want=2", rise_cyc - last_fire); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL add_busy_after got=%b want=0", busy_o); end
  endtask

  task automatic test_mul();
    got_q.delete();
    pkt_q = {8'hA1, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    send_pkt();
    wait_tx(4);
    vectors++; if (word_at(0) !== 32'h0000_0000 || got_q.size() !== 4) begin miscompares++; $display("FAIL mul_wrap got=%h (%0d bytes) want=00000000 (4 bytes)", word_at(0), got_q.size()); end
    got_q.delete();
    pkt_q = {8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_tx(4);
    vectors++; if (word_at(0) !== 32'h0000_000F || got_q.size() !== 4) begin miscompares++; $display("FAIL mul_3x5 got=%h (%0d bytes) want=0000000f (4 bytes)", word_at(0), got_q.size()); end
    vectors++; if (rise_cyc - last_fire !== 2) begin miscompares++; $display("FAIL mul_latency got=%0d want=2", rise_cyc - last_fire); end
  endtask

  task automatic test_echo_backpressure();
    logic [23:0] echoed;
    got_q.delete();
    stall_err = 0;
    bp_mode = 1;
    pkt_q = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_pkt();
    wait_tx(3);
    bp_mode = 0;
    echoed = (got_q.size() >= 3) ? {got_q[2], got_q[1], got_q[0]} : 'x;
    vectors++; if (echoed !== 24'h43_42_41) begin miscompares++; $display("FAIL echo_data got=%h want=434241", echoed); end
    vectors++; if (got_q.size() !== 3) begin miscompares++; $display("FAIL echo_bytes got=%0d want=3", got_q.size()); end
    vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL echo_stable got=%0d unstable cycles want=0", stall_err); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL echo_busy_after got=%b want=0", busy_o); end
  endtask

  task automatic test_overflow_partial();
    got_q.delete();
    pkt_q = {8'hA0, 8'h00, 8'h0E, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    wait_tx(4);
    vectors++; if (word_at(0) !== 32'h0000_0001) begin miscompares++; $display("FAIL add_overflow got=%h want=00000001", word_at(0)); end
    vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL overflow_bytes got=%0d want=4", got_q.size()); end
  endtask

  task automatic test_unknown_opcode();
    got_q.delete();
    pkt_q = {8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22,
             8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
`ifdef UART_ALU_ERR_RESP_EN
    wait_tx(5);
    vectors++; if (got_q.size() !== 5) begin miscompares++; $display("FAIL unknown_bytes got=%0d want=5", got_q.size()); end
    vectors++; if (got_q.size() < 1 || got_q[0] !== 8'hEE) begin miscompares++; $display("FAIL unknown_err_resp got=%h want=ee", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    vectors++; if (word_at(1) !== 32'h0000_0003) begin miscompares++; $display("FAIL unknown_then_add got=%h want=00000003", word_at(1)); end
`else
    wait_tx(4);
    vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL unknown_bytes got=%0d want=4", got_q.size()); end
    vectors++; if (word_at(0) !== 32'h0000_0003) begin miscompares++; $display("FAIL unknown_then_add got=%h want=00000003", word_at(0)); end
`endif
    vectors++; if (err_count_o !== 8'd1) begin miscompares++; $display("FAIL unknown_err_count got=%0d want=1", err_count_o); end
  endtask

  task automatic test_reset_mid_packet();
    got_q.delete();
    pkt_q = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
    send_pkt();
    rst_i = 1'b1;
    #1;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
    vectors++; if (rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL midrst_rx_ready got=%b want=0", rx_ready_o); end
    vectors++; if (tx_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_tx_valid got=%b want=0", tx_valid_o); end
    vectors++; if (err_count_o !== 8'd0) begin miscompares++; $display("FAIL midrst_err_count got=%0d want=0", err_count_o); end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    pkt_q = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_tx(4);
    vectors++; if (word_at(0) !== 32'h0000_000C) begin miscompares++; $display("FAIL midrst_add got=%h want=0000000c", word_at(0)); end
    vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL midrst_bytes got=%0d want=4", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    // Zero-operand add, short-length bad packet, single-operand multiply, all back to back.
    pkt_q = {8'hA0, 8'h00, 8'h04, 8'h00,
             8'h12, 8'h00, 8'h03, 8'h00,
             8'hA1, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt();
`ifdef UART_ALU_ERR_RESP_EN
    wait_tx(9);
    vectors++; if (got_q.size() !== 9) begin miscompares++; $display("FAIL b2b_bytes got=%0d want=9", got_q.size()); end
    vectors++; if (word_at(0) !== 32'h0 || got_q.size() < 5 || got_q[4] !== 8'hEE) begin miscompares++; $display("FAIL b2b_zero_and_err got=%h want=00000000 then ee", word_at(0)); end
    vectors++; if (word_at(5) !== 32'h0000_0007) begin miscompares++; $display("FAIL b2b_single_mul got=%h want=00000007", word_at(5)); end
`else
    wait_tx(8);
    vectors++; if (got_q.size() !== 8) begin miscompares++; $display("FAIL b2b_bytes got=%0d want=8", got_q.size()); end
    vectors++; if (word_at(0) !== 32'h0) begin miscompares++; $display("FAIL b2b_zero_ops got=%h want=00000000", word_at(0)); end
    vectors++; if (word_at(4) !== 32'h0000_0007) begin miscompares++; $display("FAIL b2b_single_mul got=%h want=00000007", word_at(4)); end
`endif
    vectors++; if (err_count_o !== 8'd1) begin miscompares++; $display("FAIL b2b_err_count got=%0d want=1", err_count_o); end
  endtask

  initial begin
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_echo_backpressure();
    test_overflow_partial();
    test_unknown_opcode();
    test_reset_mid_packet();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
